// File: rtl/clause_check_sequencer_pkg.sv
// Shared types and width helpers for the clause_check_sequencer block.
package clause_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4
    } seq_state_e;

    localparam int DEFAULT_SETTLE_CYCLES = 2;

    // One clause carries 2**index integer coefficients plus a constant term.
    function automatic int integer_width(input int var_index_bits, input int coeff_bits);
        return ((32'sd1 << var_index_bits) + 32'sd1) * coeff_bits;
    endfunction

    function automatic int boolean_width(input int var_index_bits, input int coeff_bits);
        return coeff_bits * (32'sd1 << var_index_bits);
    endfunction

endpackage

// File: rtl/clause_check_sequencer_if.sv
// Bus bundle between the sequencer (master), the formula memory and the checker.
interface clause_seq_if
    import clause_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int CI = 2,
    parameter int IW = integer_width(1, 4),
    parameter int BW = boolean_width(1, 2)
) ();
    logic          in_start_load;
    logic          in_start_eval;
    logic [N-1:0]  in_clause_mask;
    logic [CI-1:0] out_mem_addr;
    logic          out_mem_rd_en;
    logic [IW-1:0] in_mem_coefficients_integer;
    logic [BW-1:0] in_mem_coefficients_boolean;
    logic [IW-1:0] out_clause_coefficients_integer;
    logic [BW-1:0] out_clause_coefficients_boolean;
    logic [CI-1:0] out_clause_index;
    logic          out_clause_write;
    logic [N-1:0]  out_checker_enable;
    logic          in_satisfied;
    logic          out_busy;
    logic          out_done;
    logic          out_formula_satisfied;
    logic          out_loaded;

    modport master (
        input  in_start_load, in_start_eval, in_clause_mask,
        input  in_mem_coefficients_integer, in_mem_coefficients_boolean, in_satisfied,
        output out_mem_addr, out_mem_rd_en,
        output out_clause_coefficients_integer, out_clause_coefficients_boolean,
        output out_clause_index, out_clause_write, out_checker_enable,
        output out_busy, out_done, out_formula_satisfied, out_loaded
    );

    modport slave (
        output in_start_load, in_start_eval, in_clause_mask,
        output in_mem_coefficients_integer, in_mem_coefficients_boolean, in_satisfied,
        input  out_mem_addr, out_mem_rd_en,
        input  out_clause_coefficients_integer, out_clause_coefficients_boolean,
        input  out_clause_index, out_clause_write, out_checker_enable,
        input  out_busy, out_done, out_formula_satisfied, out_loaded
    );
endinterface

// File: rtl/clause_check_sequencer_next_index.sv
// Finds the lowest set mask bit at or above 'from'; found is low when none remain.
module clause_seq_next_index
    import clause_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int CI = 2
) (
    input  logic [N-1:0] mask,
    input  logic [CI:0]  from,
    output logic [CI:0]  idx,
    output logic         found
);
    localparam int AW = CI + 1;

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        idx   = {AW{1'b0}};
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (AW'(i) >= from)) begin
                idx   = AW'(i);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end
endmodule

// File: rtl/clause_check_sequencer.sv
// Loads clause coefficients into the checker, settles it and samples the result.
// Optional feature: SEQ_SKIP_MASKED_CLAUSES_EN loads only clauses enabled in the mask.
module clause_check_sequencer
    import clause_seq_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT     = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT     = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX  = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX  = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX           = 2,
    parameter int SETTLE_CYCLES                                = DEFAULT_SETTLE_CYCLES
) (
    input  logic         in_clk,
    input  logic         in_reset,
    clause_seq_if.master bus
);
    localparam int CI  = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int N   = 1 << CI;
    localparam int AW  = CI + 1;
    localparam int IW  = integer_width(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                                       MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT);
    localparam int BW  = boolean_width(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
                                       MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int SETTLE_LAST = SETTLE_CYCLES - 1;
`ifdef SEQ_SKIP_MASKED_CLAUSES_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    seq_state_e     state_r, state_d;
    logic [N-1:0]   mask_r, mask_d;
    logic [AW-1:0]  addr_cnt_r, addr_cnt_d;
    logic [SCW-1:0] settle_cnt_r, settle_cnt_d;
    logic           loaded_r, loaded_d;
    logic [N-1:0]   search_mask_s;
    logic [AW-1:0]  search_from_s;
    logic [AW-1:0]  next_idx_s;
    logic           next_found_s;
    logic           start_ok_s;
    logic           rd_en_r;
    logic           write_r;
    logic [CI-1:0]  wr_idx_r;
    logic [N-1:0]   enable_r;
    logic           busy_r;
    logic           done_r;
    logic           sat_r;

    // busy_r also covers the done cycle, so a start there is dropped too.
    assign start_ok_s = ~busy_r;

    // In IDLE the search seeds the first address from the incoming mask.
    assign search_mask_s = SKIP_EN ? ((state_r == ST_IDLE) ? bus.in_clause_mask : mask_r)
                                   : {N{1'b1}};
    assign search_from_s = (state_r == ST_IDLE) ? {AW{1'b0}} : (addr_cnt_r + AW'(32'd1));

    clause_seq_next_index #(.N(N), .CI(CI)) u_next_index (
        .mask  (search_mask_s),
        .from  (search_from_s),
        .idx   (next_idx_s),
        .found (next_found_s)
    );

    // State register.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Next-state and datapath-control decisions.
    always_comb begin
        state_d      = state_r;
        mask_d       = mask_r;
        addr_cnt_d   = addr_cnt_r;
        settle_cnt_d = settle_cnt_r;
        loaded_d     = loaded_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s && bus.in_start_load) begin
                    mask_d       = bus.in_clause_mask;
                    loaded_d     = 1'b0;
                    settle_cnt_d = {SCW{1'b0}};
                    if (next_found_s) begin
                        addr_cnt_d = next_idx_s;
                        state_d    = ST_LOAD;
                    end else begin
                        addr_cnt_d = {AW{1'b0}};
                        state_d    = ST_SETTLE;
                    end
                end else if (start_ok_s && bus.in_start_eval && loaded_r) begin
                    mask_d       = bus.in_clause_mask;
                    settle_cnt_d = {SCW{1'b0}};
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (next_found_s) begin
                    addr_cnt_d = next_idx_s;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                settle_cnt_d = {SCW{1'b0}};
                state_d      = ST_SETTLE;
                if (SKIP_EN) begin
                    loaded_d = (mask_r == {N{1'b1}});
                end else begin
                    loaded_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SCW'(SETTLE_LAST)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_r + SCW'(32'd1);
                end
            end
            ST_SAMPLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            mask_r       <= {N{1'b0}};
            addr_cnt_r   <= {AW{1'b0}};
            settle_cnt_r <= {SCW{1'b0}};
            loaded_r     <= 1'b0;
            rd_en_r      <= 1'b0;
            write_r      <= 1'b0;
            wr_idx_r     <= {CI{1'b0}};
            enable_r     <= {N{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            sat_r        <= 1'b0;
        end else begin
            mask_r       <= mask_d;
            addr_cnt_r   <= addr_cnt_d;
            settle_cnt_r <= settle_cnt_d;
            loaded_r     <= loaded_d;
            rd_en_r      <= (state_d == ST_LOAD);
            write_r      <= (state_r == ST_LOAD);
            wr_idx_r     <= (state_r == ST_LOAD) ? addr_cnt_r[CI-1:0] : wr_idx_r;
            enable_r     <= ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) ? mask_d : {N{1'b0}};
            busy_r       <= (state_d != ST_IDLE) || (state_r == ST_SAMPLE);
            done_r       <= (state_r == ST_SAMPLE);
            sat_r        <= (state_r == ST_SAMPLE) ? bus.in_satisfied : sat_r;
        end
    end

    // Memory data is already registered by the RAM; gating keeps idle outputs at zero.
    assign bus.out_clause_coefficients_integer = write_r ? bus.in_mem_coefficients_integer : {IW{1'b0}};
    assign bus.out_clause_coefficients_boolean = write_r ? bus.in_mem_coefficients_boolean : {BW{1'b0}};
    assign bus.out_mem_addr          = addr_cnt_r[CI-1:0];
    assign bus.out_mem_rd_en         = rd_en_r;
    assign bus.out_clause_index      = wr_idx_r;
    assign bus.out_clause_write      = write_r;
    assign bus.out_checker_enable    = enable_r;
    assign bus.out_busy              = busy_r;
    assign bus.out_done              = done_r;
    assign bus.out_formula_satisfied = sat_r;
    assign bus.out_loaded            = loaded_r;
endmodule

// File: doc/clause_check_sequencer.md
# clause_check_sequencer

Controller in front of the `UnsatisfiedClauses` checker in the stochastic-search path. It streams clause coefficients from the formula memory into the checker's clause registers, one clause per cycle. It then holds the checker enables for a fixed settle window and samples the formula-satisfied flag. It also supports re-evaluation without reloading, for each new MCMC assignment.

## Interface
Parameters:
- MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT, 4, integer coefficient width
- MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT, 2, boolean coefficient width
- MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX, 1, log2 of integer variables per clause
- MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX, 1, log2 of boolean variables per clause
- MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 2, log2 of clause count N (default N = 4)
- SETTLE_CYCLES, 2, checker evaluation cycles before sampling (≥1)

Derived widths:
- IW = (2**INT_VAR_INDEX + 1) * INT_COEFF, default 12
- BW = BOOL_COEFF * 2**BOOL_VAR_INDEX, default 4

Ports:
- in_clk  in  1  clock
- in_reset  in  1  synchronous, active-high reset
- in_start_load  in  1  pulse: load all clauses, then evaluate
- in_start_eval  in  1  pulse: evaluate only, with the already-loaded clauses
- in_clause_mask  in  N  per-clause enable, captured on start
- out_mem_addr  out  CI  formula memory read address
- out_mem_rd_en  out  1  memory read strobe; data is valid 1 cycle later
- in_mem_coefficients_integer  in  IW  memory read data, integer part
- in_mem_coefficients_boolean  in  BW  memory read data, boolean part
- out_clause_coefficients_integer  out  IW  to checker
- out_clause_coefficients_boolean  out  BW  to checker
- out_clause_index  out  CI  to checker
- out_clause_write  out  1  checker register write strobe
- out_checker_enable  out  N  to checker `in_checker_enable`
- in_satisfied  in  1  from checker `out_satisfied`
- out_busy  out  1  high from start until done
- out_done  out  1  one-cycle pulse when the result is valid
- out_formula_satisfied  out  1  sampled result, held until the next done
- out_loaded  out  1  a full load has completed since reset

## Operation
- States: IDLE, LOAD, FLUSH, SETTLE, SAMPLE.
- IDLE, on in_start_load:
  - capture the mask into mask_q
  - clear addr_cnt, clear out_loaded
  - go to LOAD
- IDLE, on in_start_eval:
  - with out_loaded = 1: capture the mask, go to SETTLE
  - with out_loaded = 0: ignore the pulse
- If both start inputs are high together, in_start_load wins.
- LOAD:
  - drive out_mem_rd_en = 1 and out_mem_addr = addr_cnt each cycle
  - remember the last issued address as wr_idx
  - in the cycle after each read, forward the memory data to the checker with out_clause_index = wr_idx and out_clause_write = 1
  - after address N-1 is issued, go to FLUSH
- FLUSH: perform the final write (index N-1), set out_loaded, go to SETTLE.
- SETTLE:
  - out_checker_enable = mask_q
  - count SETTLE_CYCLES cycles, then go to SAMPLE
- SAMPLE:
  - register in_satisfied into out_formula_satisfied
  - pulse out_done
  - go to IDLE
- out_checker_enable is zero in IDLE, LOAD and FLUSH. It equals mask_q in SETTLE and SAMPLE.
- Start pulses received while busy are ignored, not queued.
- mask_q = 0 still runs to completion. The result is whatever in_satisfied reports.
- addr_cnt is CI+1 bits wide, so the terminal compare does not wrap.

## Timing
- Reset values:
  - state IDLE
  - out_busy, out_done, out_clause_write, out_mem_rd_en: 0
  - out_checker_enable: 0
  - out_formula_satisfied: 0
  - out_loaded: 0
  - coefficient, index and address outputs: 0
- Reset mid-operation aborts immediately: next cycle is IDLE with reset values. A partial load leaves out_loaded = 0.
- Latency from start pulse (cycle 0) to out_done:
  - load: N + 2 + SETTLE_CYCLES + 1 cycles (default 9)
  - eval: 1 + SETTLE_CYCLES + 1 cycles (default 4)
- out_busy rises the cycle after the start pulse and falls the cycle after out_done.
- out_clause_write writes are back-to-back, one per cycle, indices 0..N-1 ascending.

## Configuration
- SEQ_SKIP_MASKED_CLAUSES_EN defined:
  - LOAD issues reads only for addresses whose mask_q bit is set (priority-encoded next set bit)
  - load latency becomes popcount(mask_q) + 2 + SETTLE_CYCLES + 1
  - with mask_q = 0, go straight to SETTLE with no writes
  - out_loaded is set only when mask_q is all-ones
- SEQ_SKIP_MASKED_CLAUSES_EN undefined: all N clauses are always loaded, as described above.

## Structure
- Package clause_seq_pkg holds:
  - the state enum
  - the IW/BW width computation functions
  - the default SETTLE_CYCLES constant
- One sub-module, clause_seq_next_index: combinational next-set-bit finder for the skip feature, also used for the terminal-address check.

## Test plan
- Reset, then in_start_load, mask 4'b1111, memory preloaded: writes at indices 0,1,2,3 on consecutive cycles with matching data; out_done at cycle 9; out_loaded = 1.
- in_satisfied held at 1 during SETTLE → out_formula_satisfied = 1. A following in_start_eval with in_satisfied = 0 → out_done at cycle 4 with result 0, and no memory reads.
- in_start_eval straight after reset → ignored: out_busy stays 0, no out_done.
- in_reset asserted while index 2 is being written → next cycle IDLE, all outputs at reset values, out_loaded = 0.
- Both start pulses in the same cycle → load sequence runs. Extra in_start_eval pulses while busy → no effect.
- With SEQ_SKIP_MASKED_CLAUSES_EN and mask 4'b0101 → only indices 0 and 2 written; out_done at cycle 7; out_loaded = 0.
